qar_icache: RTL and testbench
=============================

QAR_ICACHE -- requirements
Module: qar_icache

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter SETS, default 4, sets per way; power of two, at least 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cache_en  input  1  1 = cached mode, 0 = uncached bypass.
REQ-007 SHALL have port flush  input  1  single-cycle pulse that invalidates all lines.
REQ-008 SHALL have port cpu_valid  input  1  fetch request; cpu_addr is held stable until cpu_ready.
REQ-009 SHALL have port cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-010 SHALL have port cpu_ready  output  1  fetch complete; cpu_rdata is valid this cycle.
REQ-011 SHALL have port cpu_rdata  output  32  instruction word.
REQ-012 SHALL have port imem_valid, imem_addr  output  1, 32  refill or bypass request to memory.
REQ-013 SHALL have port imem_ready, imem_rdata  input  1, 32  memory handshake and data.
REQ-014 SHALL have port hit_count, miss_count  output  32, 32  performance counters.

Function
REQ-015 SHALL decode the address as offset = [log2(LINE_WORDS)+1:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-016 SHALL use FSM states IDLE, REFILL, BYPASS.
REQ-017 SHALL, in IDLE with cpu_valid, cache_en=1 and a tag match in a valid way, assert cpu_ready combinationally in the same cycle with the hit word and increment hit_count, unless the access is the replay of a miss.
REQ-018 SHALL, on an IDLE miss with cache_en=1, choose a victim way, increment miss_count, and enter REFILL.
REQ-019 SHALL issue LINE_WORDS sequential imem requests in REFILL, starting at the line base address with +4 steps.
REQ-020 SHALL hold imem_valid and imem_addr stable until imem_ready; each beat writes the returned word into the victim line.
REQ-021 SHALL, on the last beat, write the tag, set valid, return to IDLE, and serve the access in the next cycle as a hit; that replay SHALL NOT increment hit_count.
REQ-022 SHALL select as victim the lowest-index invalid way if one exists, otherwise the set's round-robin pointer.
REQ-023 SHALL advance the round-robin pointer of the refilled set by 1 modulo WAYS on every completed refill.
REQ-024 SHALL, in IDLE with cpu_valid and cache_en=0, enter BYPASS and issue a single request at {cpu_addr[31:2],2'b00}.
REQ-025 SHALL, in BYPASS, assert cpu_ready on the imem_ready cycle with imem_rdata, then return to IDLE; arrays and counters are untouched.
REQ-026 SHALL, on flush in IDLE, clear every valid bit at the clock edge; a hit lookup in that same cycle SHALL still complete.
REQ-027 SHALL, on flush during REFILL, latch a pending flag and finish the burst without aborting any beat; the line SHALL NOT be marked valid and all valid bits SHALL be cleared on completion.
REQ-028 SHALL, when flush coincides with the last refill beat, treat it as flush during REFILL.
REQ-029 SHALL let both counters wrap modulo 2^32.
REQ-030 SHALL sample cache_en only in IDLE; a change during REFILL or BYPASS has no effect until the next IDLE.

Reset
REQ-031 SHALL, while rst=1, drive state=IDLE, all valid bits 0, round-robin pointers 0, flush-pending 0, imem_valid 0, cpu_ready 0, imem_addr 0, cpu_rdata 0, hit_count 0, miss_count 0.
REQ-032 SHALL abandon any burst immediately on rst asserted mid-refill, and SHALL keep no line valid.

Verification (WAYS=2, SETS=4, LINE_WORDS=4; index=[5:4]; memory word at A = A)
REQ-033 SHALL cover a cold miss: fetch 0x00 -> imem requests 0x0/0x4/0x8/0xC; cpu_rdata=0x0; then fetch 0x4 and 0x8 -> zero imem requests; hit_count=2, miss_count=1.
REQ-034 SHALL cover a conflict: fetch 0x00, 0x40, 0x80 (all set 0) -> 0x80 evicts way0; then 0x40 hits and 0x00 misses; miss_count=4.
REQ-035 SHALL cover flush mid-refill: fetch 0x20 with flush at beat 2 -> all 4 beats complete and the word is returned; the next fetch to 0x20 misses again.
REQ-036 SHALL cover bypass: with cache_en=0, fetch 0x14 -> exactly one imem request at 0x14, cpu_rdata=0x14, counters unchanged, and a later cached fetch to 0x14 misses.
REQ-037 SHALL cover memory stall: imem_ready low for 5 cycles on beat 1 -> imem_valid=1 and imem_addr=0x4 held constant throughout.
REQ-038 SHALL cover reset mid-refill: rst during beat 2 -> imem_valid=0 asynchronously; after release, fetch 0x00 misses with a full 4-beat refill.

Source files
------------

// File: rtl/qar_icache.sv
// qar_icache: set-associative instruction cache with round-robin replacement,
// uncached bypass path and 32-bit hit/miss performance counters.
module qar_icache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_en,
  input  logic        flush,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DEPTH = WAYS * SETS * LINE_WORDS;
  localparam int DA_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REFILL, BYPASS} state_t;
  state_t state_reg, state_next;

  logic [31:0]      req_addr_reg;
  logic [OFF_W-1:0] beat_reg;
  logic [WAY_W-1:0] victim_reg, victim_next;
  logic             flush_pend_reg;
  logic             replay_reg;
  logic [31:0]      replay_word_reg;
  logic [SETS-1:0]  valid_reg [WAYS];
  logic [WAY_W-1:0] rr_reg [SETS];
  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      hit_count_reg, miss_count_reg;

  logic [OFF_W-1:0] cpu_off, req_off;
  logic [IDX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, req_tag;
  assign cpu_off = cpu_addr[OFF_W+1:2];
  assign cpu_idx = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign cpu_tag = cpu_addr[31:OFF_W+IDX_W+2];
  assign req_off = req_addr_reg[OFF_W+1:2];
  assign req_idx = req_addr_reg[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = req_addr_reg[31:OFF_W+IDX_W+2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], req_addr_reg[1:0]};

  logic [WAYS-1:0] way_hit;
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_hit[gi] = valid_reg[gi][cpu_idx] && (tag_mem[gi][cpu_idx] == cpu_tag);
    end
  endgenerate

  // Descending scan so the lowest-index hit / invalid way wins.
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit_way     = '0;
    victim_next = rr_reg[cpu_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
      if (!valid_reg[w][cpu_idx]) victim_next = WAY_W'(w);
    end
  end

  logic [DA_W-1:0] rd_ptr, wr_ptr;
  assign rd_ptr = DA_W'((int'(hit_way) * SETS + int'(cpu_idx)) * LINE_WORDS + int'(cpu_off));
  assign wr_ptr = DA_W'((int'(victim_reg) * SETS + int'(req_idx)) * LINE_WORDS + int'(beat_reg));

  logic last_beat, refill_done;
  assign last_beat   = (beat_reg == OFF_W'(LINE_WORDS - 1));
  assign refill_done = (state_reg == REFILL) && imem_ready && last_beat;

  logic hit_inc, miss_inc;
  always_comb begin
    state_next = state_reg;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    case (state_reg)
      IDLE: begin
        // The replay after a refill returns the word captured during the burst,
        // so it completes even when a flush kept the line invalid.
        if (replay_reg) begin
          if (cpu_valid) begin
            cpu_ready = 1'b1;
            cpu_rdata = replay_word_reg;
          end
        end else if (cpu_valid) begin
          if (cache_en) begin
            if (|way_hit) begin
              cpu_ready = 1'b1;
              cpu_rdata = data_mem[rd_ptr];
              hit_inc   = 1'b1;
            end else begin
              miss_inc   = 1'b1;
              state_next = REFILL;
            end
          end else begin
            state_next = BYPASS;
          end
        end
      end
      REFILL: if (refill_done) state_next = IDLE;
      BYPASS: begin
        if (imem_ready) begin
          cpu_ready  = 1'b1;
          cpu_rdata  = imem_rdata;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_valid = 1'b0;
    imem_addr  = '0;
    case (state_reg)
      REFILL: begin
        imem_valid = 1'b1;
        imem_addr  = {req_tag, req_idx, beat_reg, 2'b00};
      end
      BYPASS: begin
        imem_valid = 1'b1;
        imem_addr  = {req_addr_reg[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      req_addr_reg    <= '0;
      beat_reg        <= '0;
      victim_reg      <= '0;
      flush_pend_reg  <= 1'b0;
      replay_reg      <= 1'b0;
      replay_word_reg <= '0;
      hit_count_reg   <= '0;
      miss_count_reg  <= '0;
      for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
    end else begin
      state_reg  <= state_next;
      replay_reg <= refill_done;
      if (state_reg == IDLE && state_next != IDLE) begin
        req_addr_reg <= cpu_addr;
        beat_reg     <= '0;
        victim_reg   <= victim_next;
      end
      if (state_reg == REFILL && imem_ready) begin
        beat_reg <= beat_reg + 1'b1;
        if (beat_reg == req_off) replay_word_reg <= imem_rdata;
      end
      if (refill_done) begin
        rr_reg[req_idx] <= (rr_reg[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[req_idx] + 1'b1;
        flush_pend_reg  <= 1'b0;
        if (flush_pend_reg || flush) begin
          for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
        end else begin
          valid_reg[victim_reg][req_idx] <= 1'b1;
        end
      end else if (flush) begin
        if (state_reg == REFILL) flush_pend_reg <= 1'b1;
        else for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
      end
      if (hit_inc)  hit_count_reg  <= hit_count_reg + 32'd1;
      if (miss_inc) miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  // Line storage carries no reset; validity alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (state_reg == REFILL && imem_ready) begin
      data_mem[wr_ptr] <= imem_rdata;
      if (last_beat) tag_mem[victim_reg][req_idx] <= req_tag;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
endmodule

// File: tb/tb_qar_icache.sv
// Directed bench for qar_icache: a table of fetches plus hand-built sequences
// for flush, stall and reset during a refill burst. Memory returns its address.
module tb_qar_icache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cache_en = 1'b1;
  logic        flush = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] hit_count, miss_count;
  logic        stall = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] req_log[$];

  qar_icache #(.WAYS(2), .SETS(4), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .cache_en(cache_en), .flush(flush),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_ready = imem_valid && !stall;
    imem_rdata = imem_addr;
  end

  always @(posedge clk) begin
    if (imem_valid && imem_ready) req_log.push_back(imem_addr);
  end

  typedef struct {
    logic [31:0] addr;
    logic        en;
    logic [31:0] rdata;
    int          beats;
    logic [31:0] base;
    int          hits;
    int          misses;
  } vec_t;
  vec_t vecs[10];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic check_beats(input string name, input int exp_n, input logic [31:0] base);
    logic ok;
    ok = (req_log.size() == exp_n);
    for (int i = 0; i < req_log.size() && ok; i++)
      if (req_log[i] !== base + 32'(4 * i)) ok = 1'b0;
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s beats: got %0d requests (first 0x%08h) expected %0d from 0x%08h",
                  name, req_log.size(), (req_log.size() > 0) ? req_log[0] : 32'hx, exp_n, base);
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic ok);
    cpu_addr  = a;
    cpu_valid = 1'b1;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        d  = cpu_rdata;
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
  endtask

  task automatic fetch_check(input string name, input logic [31:0] a, input logic en,
                             input logic [31:0] exp_d, input int exp_beats,
                             input logic [31:0] base, input int exp_h, input int exp_m);
    logic [31:0] d;
    logic ok;
    cache_en = en;
    req_log.delete();
    fetch(a, d, ok);
    $display("txn %s addr=0x%08h en=%0b data=0x%08h beats=%0d hits=%0d misses=%0d",
             name, a, en, d, req_log.size(), hit_count, miss_count);
    check32({name, " ready"}, {31'd0, ok}, 32'd1);
    check32({name, " rdata"}, d, exp_d);
    check_beats(name, exp_beats, base);
    check32({name, " hit_count"}, hit_count, 32'(exp_h));
    check32({name, " miss_count"}, miss_count, 32'(exp_m));
  endtask

  task automatic wait_addr(input logic [31:0] a, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (imem_valid && imem_addr == a) seen = 1'b1;
    end
  endtask

  task automatic flush_at(input string name, input logic [31:0] a);
    logic seen;
    wait_addr(a, seen);
    check32({name, " trigger"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
  endtask

  task automatic stall_at(input string name, input logic [31:0] a);
    logic seen, held;
    wait_addr(a, seen);
    check32({name, " trigger"}, {31'd0, seen}, 32'd1);
    held = 1'b1;
    if (seen) begin
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (!(imem_valid && imem_addr == a)) held = 1'b0;
      end
      stall = 1'b0;
    end
    check32({name, " held"}, {31'd0, held}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vecs[0] = '{32'h00, 1'b1, 32'h00, 4, 32'h00, 0, 1};
    vecs[1] = '{32'h04, 1'b1, 32'h04, 0, 32'h00, 1, 1};
    vecs[2] = '{32'h08, 1'b1, 32'h08, 0, 32'h00, 2, 1};
    vecs[3] = '{32'h40, 1'b1, 32'h40, 4, 32'h40, 2, 2};
    vecs[4] = '{32'h80, 1'b1, 32'h80, 4, 32'h80, 2, 3};
    vecs[5] = '{32'h44, 1'b1, 32'h44, 0, 32'h00, 3, 3};
    vecs[6] = '{32'h00, 1'b1, 32'h00, 4, 32'h00, 3, 4};
    vecs[7] = '{32'h14, 1'b0, 32'h14, 1, 32'h14, 3, 4};
    vecs[8] = '{32'h14, 1'b1, 32'h14, 4, 32'h10, 3, 5};
    vecs[9] = '{32'h18, 1'b1, 32'h18, 0, 32'h00, 4, 5};

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #2;
    check32("rst imem_valid", {31'd0, imem_valid}, 32'd0);
    check32("rst imem_addr", imem_addr, 32'd0);
    check32("rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check32("rst cpu_rdata", cpu_rdata, 32'd0);
    check32("rst hit_count", hit_count, 32'd0);
    check32("rst miss_count", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      fetch_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].en, vecs[i].rdata,
                  vecs[i].beats, vecs[i].base, vecs[i].hits, vecs[i].misses);

    // Flush at beat 2 of a refill: burst finishes, word returned, line not kept.
    fork
      fetch_check("flush_mid", 32'h20, 1'b1, 32'h20, 4, 32'h20, 4, 6);
      flush_at("flush_mid", 32'h28);
    join
    fetch_check("after_flush_mid", 32'h20, 1'b1, 32'h20, 4, 32'h20, 4, 7);
    fetch_check("set0_flushed", 32'h00, 1'b1, 32'h00, 4, 32'h00, 4, 8);
    fetch_check("hit_0x24", 32'h24, 1'b1, 32'h24, 0, 32'h00, 5, 8);

    // Flush in IDLE alongside a hit: the hit completes, then the line is gone.
    flush = 1'b1;
    fetch_check("idle_flush_hit", 32'h24, 1'b1, 32'h24, 0, 32'h00, 6, 8);
    flush = 1'b0;
    fetch_check("after_idle_flush", 32'h24, 1'b1, 32'h24, 4, 32'h20, 6, 9);

    fork
      fetch_check("stall", 32'h100, 1'b1, 32'h100, 4, 32'h100, 6, 10);
      stall_at("stall", 32'h104);
    join

    fork
      fetch_check("flush_last", 32'h30, 1'b1, 32'h30, 4, 32'h30, 6, 11);
      flush_at("flush_last", 32'h3C);
    join
    fetch_check("after_flush_last", 32'h30, 1'b1, 32'h30, 4, 32'h30, 6, 12);

    // Reset asserted between clock edges during beat 2.
    cache_en  = 1'b1;
    cpu_addr  = 32'h00;
    cpu_valid = 1'b1;
    wait_addr(32'h08, seen);
    check32("mid_rst trigger", {31'd0, seen}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check32("mid_rst imem_valid", {31'd0, imem_valid}, 32'd0);
    check32("mid_rst imem_addr", imem_addr, 32'd0);
    check32("mid_rst miss_count", miss_count, 32'd0);
    cpu_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fetch_check("post_rst", 32'h00, 1'b1, 32'h00, 4, 32'h00, 0, 1);
    fetch_check("post_rst_hit", 32'h04, 1'b1, 32'h04, 0, 32'h00, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
